// File: rtl/float_to_int_staged_if.sv
// -----------------------------------------------------------------------------
// float_to_int_staged_if
//   Streaming bundle for the float-to-integer converter: one valid/ready input
//   channel carrying an IEEE-754 single, and one valid/ready output channel
//   carrying the signed 32-bit result plus an invalid-operation flag.
//
//   Signals
//     in_valid    producer -> converter   in_value holds an operand
//     in_ready    converter -> producer   operand is taken this cycle
//     in_value    producer -> converter   {sign[31], exp[30:23], frac[22:0]}
//     out_valid   converter -> consumer   out_value/out_invalid hold a result
//     out_ready   consumer -> converter   result is taken this cycle
//     out_value   converter -> consumer   two's-complement integer result
//     out_invalid converter -> consumer   NaN, infinity or overflow
//
//   Modports
//     master : producer/consumer side (the environment around the converter)
//     slave  : converter side
// -----------------------------------------------------------------------------
interface float_to_int_staged_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_value;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_value;
   logic        out_invalid;

   modport master (
      output in_valid,
      output in_value,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_value,
      input  out_invalid
   );

   modport slave (
      input  in_valid,
      input  in_value,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_value,
      output out_invalid
   );
endinterface

// File: rtl/float_to_int_staged.sv
// -----------------------------------------------------------------------------
// float_to_int_staged
//   Three-stage pipelined IEEE-754 single-precision to signed 32-bit integer
//   converter used by the FTOI instruction.
//     S1 unpack : sign, unbiased exponent, mantissa with hidden bit, class
//     S2 align  : shift mantissa into a 32-bit magnitude, detect overflow
//     S3 sign   : negate, saturate / flag invalid, register the result
//   All three stages advance together when the output stage is empty or the
//   consumer is taking its result, so the pipeline holds up to 3 entries.
//
//   Ports
//     clk    : clock, all state on the rising edge
//     reset  : synchronous active-high reset, discards everything in flight
//     bus    : float_to_int_staged_if.slave (in_valid/in_ready/in_value,
//              out_valid/out_ready/out_value/out_invalid)
//
//   Parameters
//     SATURATE : 1 clamps out-of-range results by sign (NaN -> 0x7FFFFFFF);
//                0 returns 0x80000000 for every invalid case.
//
//   Build option
//     FTOI_ROUND_NEAREST_EN : when defined, S2 keeps guard/sticky bits and the
//     magnitude is rounded to nearest, ties to even; when undefined the
//     conversion truncates toward zero.
// -----------------------------------------------------------------------------
module float_to_int_staged #(
   parameter bit SATURATE = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   float_to_int_staged_if.slave  bus
);

   // ---------------------------------------------------------------- control
   logic adv_s;

   // ---------------------------------------------------------------- stage 1
   logic              s1_valid_q;
   logic              s1_sign_q,  s1_sign_d;
   logic signed [8:0] s1_exp_q,   s1_exp_d;
   logic [23:0]       s1_mant_q,  s1_mant_d;
   logic              s1_zero_q,  s1_zero_d;
   logic              s1_nan_q,   s1_nan_d;
   logic              s1_inf_q,   s1_inf_d;

   // ---------------------------------------------------------------- stage 2
   logic              s2_valid_q;
   logic              s2_sign_q;
   logic [31:0]       s2_mag_q,   s2_mag_d;
   logic              s2_nan_q;
   logic              s2_ovf_q,   s2_ovf_d;
   logic [4:0]        rsh_s;
   logic [2:0]        lsh_s;
`ifdef FTOI_ROUND_NEAREST_EN
   logic              s2_guard_q,  s2_guard_d;
   logic              s2_sticky_q, s2_sticky_d;
   logic [24:0]       ext_s;
`endif

   // ---------------------------------------------------------------- stage 3
   logic              s3_valid_q;
   logic [31:0]       s3_value_q,   s3_value_d;
   logic              s3_invalid_q, s3_invalid_d;
   logic [31:0]       mag_rnd_s;

   // The whole pipeline moves as one unit; it only stops when a finished
   // result is sitting in S3 and the consumer refuses it.
   assign adv_s           = !s3_valid_q || bus.out_ready;
   assign bus.in_ready    = adv_s;
   assign bus.out_valid   = s3_valid_q;
   assign bus.out_value   = s3_value_q;
   assign bus.out_invalid = s3_invalid_q;

   // S1 unpack: split fields, remove exponent bias, classify special operands
   always_comb begin
      s1_sign_d = bus.in_value[31];
      s1_exp_d  = $signed({1'b0, bus.in_value[30:23]}) - 9'sd127;
      s1_mant_d = {1'b1, bus.in_value[22:0]};
      s1_zero_d = (bus.in_value[30:23] == 8'd0);
      s1_nan_d  = (bus.in_value[30:23] == 8'hFF) && (bus.in_value[22:0] != 23'd0);
      s1_inf_d  = (bus.in_value[30:23] == 8'hFF) && (bus.in_value[22:0] == 23'd0);
   end

   // S2 align: turn the mantissa/exponent pair into an unsigned magnitude
   always_comb begin
      s2_mag_d = 32'd0;
      s2_ovf_d = 1'b0;
      // For -1 <= e <= 23 the right shift 23-e fits in 5 bits, so the low
      // exponent bits give it directly (e=-1 wraps to a shift of 24).
      rsh_s    = 5'd23 - s1_exp_q[4:0];
      // For 24 <= e <= 30 the left shift e-23 is (e+1) mod 8.
      lsh_s    = s1_exp_q[2:0] + 3'd1;
`ifdef FTOI_ROUND_NEAREST_EN
      s2_guard_d  = 1'b0;
      s2_sticky_d = 1'b0;
      // Mantissa with one extra zero below it: bit rsh_s is the first bit
      // shifted out (guard), the bits beneath it form the sticky bit.
      ext_s       = {s1_mant_q, 1'b0};
`endif
      if (s1_zero_q) begin
         s2_mag_d = 32'd0;
      end else if (s1_nan_q || s1_inf_q) begin
         // NaN is carried separately; only infinity is treated as overflow.
         s2_ovf_d = s1_inf_q;
      end else if (s1_exp_q < -9'sd1) begin
         // |x| < 0.5: nothing survives, and it can never round up.
         s2_mag_d = 32'd0;
`ifdef FTOI_ROUND_NEAREST_EN
         s2_sticky_d = 1'b1;
`endif
      end else if (s1_exp_q <= 9'sd23) begin
         s2_mag_d = {8'd0, s1_mant_q} >> rsh_s;
`ifdef FTOI_ROUND_NEAREST_EN
         s2_guard_d  = ext_s[rsh_s];
         s2_sticky_d = |(ext_s & ((25'd1 << rsh_s) - 25'd1));
`endif
      end else if (s1_exp_q <= 9'sd30) begin
         s2_mag_d = {8'd0, s1_mant_q} << lsh_s;
      end else if (s1_sign_q && (s1_exp_q == 9'sd31) && (s1_mant_q == 24'h80_0000)) begin
         // Exactly -2^31 is the one representable value with e = 31.
         s2_mag_d = 32'h8000_0000;
      end else begin
         s2_ovf_d = 1'b1;
      end
   end

   // S3 sign/saturate: optional rounding, then negate or substitute a clamp
   always_comb begin
      mag_rnd_s    = s2_mag_q;
`ifdef FTOI_ROUND_NEAREST_EN
      // Round half to even; the magnitude is below 2^24 here so no carry out.
      mag_rnd_s    = s2_mag_q + {31'd0, s2_guard_q & (s2_sticky_q | s2_mag_q[0])};
`endif
      s3_value_d   = 32'd0;
      s3_invalid_d = 1'b0;
      if (s2_nan_q) begin
         s3_invalid_d = 1'b1;
         if (SATURATE) begin
            s3_value_d = 32'h7FFF_FFFF;
         end else begin
            s3_value_d = 32'h8000_0000;
         end
      end else if (s2_ovf_q) begin
         s3_invalid_d = 1'b1;
         if (SATURATE && !s2_sign_q) begin
            s3_value_d = 32'h7FFF_FFFF;
         end else begin
            s3_value_d = 32'h8000_0000;
         end
      end else if (s2_sign_q) begin
         // A zero magnitude negates to zero, so -0 never appears.
         s3_value_d = ~mag_rnd_s + 32'd1;
      end else begin
         s3_value_d = mag_rnd_s;
      end
   end

   // Pipeline registers: cleared by reset, otherwise shift together on adv_s
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q   <= 1'b0;
         s1_sign_q    <= 1'b0;
         s1_exp_q     <= 9'sd0;
         s1_mant_q    <= 24'd0;
         s1_zero_q    <= 1'b0;
         s1_nan_q     <= 1'b0;
         s1_inf_q     <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_sign_q    <= 1'b0;
         s2_mag_q     <= 32'd0;
         s2_nan_q     <= 1'b0;
         s2_ovf_q     <= 1'b0;
`ifdef FTOI_ROUND_NEAREST_EN
         s2_guard_q   <= 1'b0;
         s2_sticky_q  <= 1'b0;
`endif
         s3_valid_q   <= 1'b0;
         s3_value_q   <= 32'd0;
         s3_invalid_q <= 1'b0;
      end else if (adv_s) begin
         s1_valid_q   <= bus.in_valid;
         s1_sign_q    <= s1_sign_d;
         s1_exp_q     <= s1_exp_d;
         s1_mant_q    <= s1_mant_d;
         s1_zero_q    <= s1_zero_d;
         s1_nan_q     <= s1_nan_d;
         s1_inf_q     <= s1_inf_d;
         s2_valid_q   <= s1_valid_q;
         s2_sign_q    <= s1_sign_q;
         s2_mag_q     <= s2_mag_d;
         s2_nan_q     <= s1_nan_q;
         s2_ovf_q     <= s2_ovf_d;
`ifdef FTOI_ROUND_NEAREST_EN
         s2_guard_q   <= s2_guard_d;
         s2_sticky_q  <= s2_sticky_d;
`endif
         s3_valid_q   <= s2_valid_q;
         s3_value_q   <= s3_value_d;
         s3_invalid_q <= s3_invalid_d;
      end
   end

endmodule

// File: tb/tb_float_to_int_staged.sv
// -----------------------------------------------------------------------------
// tb_float_to_int_staged
//   Drives two converters (SATURATE=1 and SATURATE=0) with the same stream and
//   compares every emitted result with a real-arithmetic reference model.
//   Directed items additionally carry a hand-computed expected value.
// -----------------------------------------------------------------------------
module tb_float_to_int_staged;

   typedef struct {
      logic [31:0] f;
      bit          has_k;
      logic [31:0] kv;
      logic        ki;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   ent_t exp_q[$];
   bit          cur_hk;
   logic [31:0] cur_kv;
   logic        cur_ki;
   bit          rnd_ready;

   float_to_int_staged_if bus_sat ();
   float_to_int_staged_if bus_wrap ();

   float_to_int_staged #(.SATURATE(1'b1)) dut_sat  (.clk(clk), .reset(reset), .bus(bus_sat));
   float_to_int_staged #(.SATURATE(1'b0)) dut_wrap (.clk(clk), .reset(reset), .bus(bus_wrap));

   assign bus_wrap.in_valid  = bus_sat.in_valid;
   assign bus_wrap.in_value  = bus_sat.in_value;
   assign bus_wrap.out_ready = bus_sat.out_ready;

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=%h required=%h", tag, obs, req);
      end
   endtask

   // Reference: value of the float as a real, truncated (or rounded half-even),
   // then range-checked against the int32 range.
   function automatic void model(input logic [31:0] f, input bit sat,
                                 output logic [31:0] v, output logic inv);
      int     ex;
      real    scale, mag, whole, sv;
      longint li;
`ifdef FTOI_ROUND_NEAREST_EN
      real    fp;
`endif
      ex  = int'(f[30:23]);
      v   = 32'd0;
      inv = 1'b0;
      if (ex == 255) begin
         inv = 1'b1;
         if (f[22:0] != 23'd0) v = sat ? 32'h7FFF_FFFF : 32'h8000_0000;
         else                  v = (sat && !f[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
      end else if (ex != 0) begin
         scale = 1.0;
         for (int i = 0; i < ex - 127; i++) scale = scale * 2.0;
         for (int i = 0; i < 127 - ex; i++) scale = scale / 2.0;
         mag   = (1.0 + real'(f[22:0]) / 8388608.0) * scale;
         whole = $floor(mag);
`ifdef FTOI_ROUND_NEAREST_EN
         fp = mag - whole;
         if (fp > 0.5 || (fp == 0.5 && (whole / 2.0 != $floor(whole / 2.0))))
            whole = whole + 1.0;
`endif
         sv = f[31] ? -whole : whole;
         if (sv > 2147483647.0 || sv < -2147483648.0) begin
            inv = 1'b1;
            v   = (sat && !f[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
         end else begin
            li = longint'(sv);
            v  = li[31:0];
         end
      end
   endfunction

   // Scoreboard: pop on output transfer and compare, push on input accept
   always @(negedge clk) begin
      ent_t        e;
      logic [31:0] mv;
      logic        mi;
      if (!reset) begin
         if (bus_sat.out_valid && bus_sat.out_ready) begin
            chk("queue_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               model(e.f, 1'b1, mv, mi);
               chk("sat_value", bus_sat.out_value, mv);
               chk("sat_invalid", {31'd0, bus_sat.out_invalid}, {31'd0, mi});
               if (e.has_k) begin
                  chk("directed_value", bus_sat.out_value, e.kv);
                  chk("directed_invalid", {31'd0, bus_sat.out_invalid}, {31'd0, e.ki});
               end
               model(e.f, 1'b0, mv, mi);
               chk("wrap_valid", {31'd0, bus_wrap.out_valid}, 32'd1);
               chk("wrap_value", bus_wrap.out_value, mv);
               chk("wrap_invalid", {31'd0, bus_wrap.out_invalid}, {31'd0, mi});
            end
         end
         if (bus_sat.in_valid && bus_sat.in_ready)
            exp_q.push_back('{f: bus_sat.in_value, has_k: cur_hk, kv: cur_kv, ki: cur_ki});
      end
   end

   // Present one operand and hold it until accepted; starts/ends at posedge+1
   task automatic send(input logic [31:0] f, input bit hk, input logic [31:0] kv, input logic ki);
      bit done;
      int waits;
      bus_sat.in_valid = 1'b1;
      bus_sat.in_value = f;
      cur_hk = hk; cur_kv = kv; cur_ki = ki;
      done = 1'b0; waits = 0;
      while (!done) begin
         if (rnd_ready) bus_sat.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (bus_sat.in_ready) begin
            done = 1'b1;
         end else begin
            waits++;
            if (waits > 50) begin
               checks++; errors++;
               $error("FAIL accept_timeout observed=%0d required<=50", waits);
               done = 1'b1;
            end
         end
         @(posedge clk); #1;
      end
      bus_sat.in_valid = 1'b0;
   endtask

   task automatic drain();
      bus_sat.in_valid  = 1'b0;
      bus_sat.out_ready = 1'b1;
      for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
         @(posedge clk); #1;
      end
      chk("drain_empty", exp_q.size(), 32'd0);
   endtask

   // Called right after the accept edge with an empty, unstalled pipeline
   task automatic latency_check(input string tag);
      @(negedge clk); chk({tag, "_c1"}, {31'd0, bus_sat.out_valid}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk); chk({tag, "_c2"}, {31'd0, bus_sat.out_valid}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk); chk({tag, "_c3"}, {31'd0, bus_sat.out_valid}, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_valid"},   {31'd0, bus_sat.out_valid},   32'd0);
      chk({tag, "_value"},   bus_sat.out_value,            32'd0);
      chk({tag, "_invalid"}, {31'd0, bus_sat.out_invalid}, 32'd0);
      chk({tag, "_wvalid"},  {31'd0, bus_wrap.out_valid},  32'd0);
      chk({tag, "_wvalue"},  bus_wrap.out_value,           32'd0);
   endtask

   logic [31:0] dir_f [0:14];
   logic [31:0] dir_k [0:14];
   logic        dir_i [0:14];
   logic [31:0] bp_vals [0:4];

   initial begin
      int          idx;
      logic [31:0] rv, f, mask;
      logic [7:0]  ex;
      int          r;

      dir_f = '{32'hC2F6_E979, 32'h4F00_0000, 32'hCF00_0000, 32'hFF80_0000, 32'h7FC0_0000,
                32'h0000_0001, 32'h8000_0000, 32'h3F7F_FFFF, 32'h4B7F_FFFF,
                32'h3FC0_0000, 32'h4020_0000, 32'h3F40_0000, 32'h3F00_0000, 32'hC060_0000,
                32'h7F80_0000};
`ifdef FTOI_ROUND_NEAREST_EN
      dir_k = '{32'hFFFF_FF85, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                32'd0, 32'd0, 32'd1, 32'h00FF_FFFF,
                32'd2, 32'd2, 32'd1, 32'd0, 32'hFFFF_FFFC,
                32'h7FFF_FFFF};
`else
      dir_k = '{32'hFFFF_FF85, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                32'd0, 32'd0, 32'd0, 32'h00FF_FFFF,
                32'd1, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFD,
                32'h7FFF_FFFF};
`endif
      dir_i = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      bp_vals = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};

      rnd_ready = 1'b0;
      cur_hk = 1'b0; cur_kv = 32'd0; cur_ki = 1'b0;
      reset = 1'b1;
      bus_sat.in_valid  = 1'b0;
      bus_sat.in_value  = 32'd0;
      bus_sat.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_idle("reset");
      @(posedge clk); #1;

      // First conversion with exact-latency check
      bus_sat.out_ready = 1'b1;
      send(32'h4049_0FDB, 1'b1, 32'd3, 1'b0);
      latency_check("latency_pi");

      // Directed table: signs, invalids, zero/denormal, boundaries, rounding
      for (int i = 0; i < 15; i++) send(dir_f[i], 1'b1, dir_k[i], dir_i[i]);
      drain();

      // Backpressure: five back-to-back inputs, consumer stalled 6 cycles
      idx = 0;
      for (int c = 0; c < 40 && idx < 5; c++) begin
         bus_sat.out_ready = (c >= 6);
         bus_sat.in_valid  = 1'b1;
         bus_sat.in_value  = bp_vals[idx];
         cur_hk = 1'b1; cur_kv = 32'(idx + 1); cur_ki = 1'b0;
         @(negedge clk);
         if (c < 3) chk("bp_ready_open", {31'd0, bus_sat.in_ready}, 32'd1);
         if (c >= 3 && c <= 5) begin
            chk("bp_ready_closed", {31'd0, bus_sat.in_ready}, 32'd0);
            chk("bp_hold_valid",   {31'd0, bus_sat.out_valid}, 32'd1);
            chk("bp_hold_value",   bus_sat.out_value, 32'd1);
         end
         if (bus_sat.in_ready) idx++;
         @(posedge clk); #1;
      end
      drain();

      // Reset with three entries in flight
      bus_sat.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(32'h4040_0000, 1'b0, 32'd0, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check_idle("flush");
      @(posedge clk); #1;
      bus_sat.out_ready = 1'b1;
      repeat (6) begin @(posedge clk); #1; end
      send(32'h4120_0000, 1'b1, 32'h0000_000A, 1'b0);
      latency_check("latency_ten");
      drain();

      // Randomised stream with random consumer stalls and input bubbles
      rnd_ready = 1'b1;
      for (int n = 0; n < 400; n++) begin
         r  = $urandom_range(0, 9);
         rv = $urandom();
         if (r <= 4)      ex = 8'($urandom_range(110, 160));
         else if (r == 5) ex = 8'd0;
         else if (r == 6) ex = 8'hFF;
         else if (r == 7) ex = 8'($urandom_range(156, 160));
         else             ex = 8'($urandom_range(124, 134));
         mask = 32'h007F_FFFF << $urandom_range(0, 23);
         f = {rv[31], ex, rv[22:0] & mask[22:0]};
         send(f, 1'b0, 32'd0, 1'b0);
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
         end
      end
      rnd_ready = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/float_to_int_staged.md
Name: float_to_int_staged

Overview:
- Three-stage pipelined converter from IEEE-754 single-precision to 32-bit two's-complement integer.
- It unpacks, aligns and negates in the opposite direction to the floating adder's normalise/pack path.
- Sits between the register file and integer datapath for the FTOI instruction.
- Valid/ready streaming on both sides; one conversion per clock when not stalled.

Parameters:
- SATURATE, 1, 1: out-of-range results clamp by sign; 0: every invalid case returns 0x80000000.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_value is valid this cycle
- in_ready  output  1  block accepts in_value this cycle
- in_value  input  32  float operand {sign[31], exp[30:23], frac[22:0]}
- out_valid  output  1  out_value/out_invalid are valid
- out_ready  input  1  consumer accepts output this cycle
- out_value  output  32  signed integer result
- out_invalid  output  1  NaN, infinity or overflow occurred

Behaviour:
- Reset (reset=1 at clk edge): all stage valid bits cleared. Next cycle out_valid=0, out_value=0, out_invalid=0.
- Reset wins over every in-flight transfer. Data in flight when reset is asserted is discarded, never emitted.
- Pipeline advance: adv = !s3_valid || out_ready. All three stages shift together when adv=1 and hold when adv=0.
- in_ready = adv. This is combinational from out_ready and s3_valid; this is intentional.
- Accept occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Latency is exactly 3 cycles from accept to out_valid when not stalled. Full throughput is 1 per cycle.
- Stall capacity is 3 entries. Order is preserved, with no loss and no duplication.
- Bubbles (in_valid=0 while adv=1) propagate as invalid stages.
- S1 (unpack):
  - Latch sign.
  - e = exp - 127, 9-bit signed.
  - mant = {1, frac}, 24 bits.
  - Classify: zero/denormal (exp=0), NaN (exp=255, frac!=0), Inf (exp=255, frac=0).
- S2 (align):
  - e<0: magnitude 0.
  - 0<=e<=23: mant >> (23-e), truncating toward zero.
  - 24<=e<=30: mant << (e-23).
  - e>=31: overflow, except the exact case sign=1, exp=158, frac=0, which is exactly -2^31 and legal.
  - Magnitude is held in 32 bits.
- S3 (sign/saturate):
  - Result = sign ? -mag : mag, computed in 32 bits.
  - Zero/denormal, either sign: 0x00000000, out_invalid=0. Result is never -0 or nonzero.
  - With SATURATE=1:
    - overflow/Inf with sign=0: 0x7FFFFFFF
    - overflow/Inf with sign=1: 0x80000000
    - NaN: 0x7FFFFFFF
    - out_invalid=1 in all three cases.
  - With SATURATE=0: every invalid case gives 0x80000000 with out_invalid=1.
- out_value and out_invalid are registered S3 contents. They stay stable while out_valid && !out_ready.

Optional Feature:
- Macro FTOI_ROUND_NEAREST_EN.
- Defined:
  - S2 keeps guard and sticky bits for e<=23, including e=-1, where guard=hidden bit.
  - Magnitude rounds to nearest, ties to even, before S3.
  - Increment never overflows because magnitude < 2^24.
  - Latency is unchanged.
- Undefined: truncation toward zero; guard/sticky logic is absent.

Test Plan:
- 0x40490FDB (3.14159) accepted, out_ready=1 -> out_value 0x00000003, out_invalid 0, out_valid exactly 3 cycles after accept. Then 0xC2F6E979 (-123.456) -> 0xFFFFFF85.
- 0x4F000000 (2^31) -> 0x7FFFFFFF, invalid 1. 0xCF000000 (-2^31) -> 0x80000000, invalid 0. 0xFF800000 (-Inf) -> 0x80000000, invalid 1. 0x7FC00000 (NaN) -> 0x7FFFFFFF, invalid 1. With SATURATE=0 all four invalid cases -> 0x80000000.
- 0x00000001 (denormal) -> 0; 0x80000000 (-0) -> 0; 0x3F7FFFFF (0.99999994) -> 0; 0x4B7FFFFF (16777215.0) -> 0x00FFFFFF; all invalid 0.
- Backpressure: five back-to-back inputs (1.0, 2.0, 3.0, 4.0, 5.0) with out_ready=0 for 6 cycles. in_ready drops after the third accept. After out_ready=1, outputs are 1,2,3,4,5 in order with no duplicates, and out_value is stable while stalled.
- Reset asserted with 3 valid entries in flight -> out_valid=0 the next cycle, and no stale result appears afterwards. A fresh 0x41200000 (10.0) -> 0x0000000A after 3 cycles.
- With FTOI_ROUND_NEAREST_EN:
  - 0x3FC00000 (1.5) -> 2
  - 0x40200000 (2.5) -> 2
  - 0x3F400000 (0.75) -> 1
  - 0x3F000000 (0.5) -> 0
  - 0xC0600000 (-3.5) -> 0xFFFFFFFC
  - Without the macro these give 1, 2, 0, 0, 0xFFFFFFFD.
